qcl_hold_timer: RTL and testbench
=================================

# qcl_hold_timer

Programmable hold-time sequencer that sits directly upstream of a set/reset flip-flop: on a trigger it emits a one-cycle `set_o` pulse, then a one-cycle `clear_o` pulse exactly `hold_cycles_i` cycles later, holding the flop's output high for that window. It supports retrigger (extend), abort, and a mandatory inter-window gap. It guarantees that `set_o` and `clear_o` are never asserted in the same cycle, which the downstream flop treats as a fatal error.

## Interface
Parameters:
- `cnt_width_p`, 16, width of the hold-cycle count and internal counter.
- `min_gap_p`, 1, idle cycles enforced after `clear_o` before a new trigger is accepted. Must be ≥1 and < 2^`cnt_width_p`; an elaboration-time error otherwise.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `trigger_i`  in  1  start (IDLE) or retrigger (HOLD) request, sampled every cycle.
- `hold_cycles_i`  in  `cnt_width_p`  window length N, sampled on an accepted trigger or retrigger.
- `retrigger_en_i`  in  1  allows a trigger in HOLD to reload the counter.
- `abort_i`  in  1  ends the HOLD window early.
- `set_o`  out  1  one-cycle pulse to downstream set.
- `clear_o`  out  1  one-cycle pulse to downstream reset.
- `busy_o`  out  1  state ≠ IDLE.
- `remaining_o`  out  `cnt_width_p`  counter value in HOLD; 0 in IDLE and GAP.
- `drop_o`  out  1  one-cycle pulse: a trigger was rejected.

## Operation
- States (shared enum): IDLE, HOLD, GAP. One down-counter `cnt`.
- Reset: next cycle state=IDLE, cnt=0. All outputs 0.
  - No `clear_o` is emitted on reset mid-HOLD; the downstream flop shares the same reset.
- IDLE:
  - `trigger_i` with N≠0: state→HOLD, cnt←N, `set_o`←1.
  - `trigger_i` with N=0: `drop_o`←1, stay in IDLE.
  - `abort_i` is ignored.
- HOLD, per cycle, priority highest first:
  - `abort_i`: `clear_o`←1, state→GAP, cnt←`min_gap_p`.
  - `trigger_i` with `retrigger_en_i`=1 and N≠0: cnt←N. No new `set_o`.
  - `trigger_i` otherwise: `drop_o`←1. Counting continues.
  - cnt==1: `clear_o`←1, state→GAP, cnt←`min_gap_p`.
  - else: cnt←cnt−1.
  - A dropped trigger and cnt==1 in the same cycle produce both `drop_o` and `clear_o`.
- GAP:
  - `trigger_i` → `drop_o`←1.
  - cnt==1: state→IDLE. Else cnt←cnt−1.
  - `abort_i` is ignored.
- Invariant: `set_o & clear_o` is never 1. Covered by a simulation-only assertion.
- `set_o` only ever follows IDLE; `clear_o` only ever follows HOLD. So pulses strictly alternate: set, clear, set, …

## Timing
- All outputs are registered. Latency from a trigger in cycle T to `set_o` is 1 (cycle T+1).
- Without retrigger or abort:
  - `remaining_o` = N at T+1, decrementing to 1 at T+N.
  - `clear_o` is high at T+N+1.
  - The downstream flop output is high for exactly N cycles (T+2 … T+N+1).
- Abort sampled in cycle A: `clear_o` at A+1.
- Retrigger sampled in cycle R: `remaining_o` = N' at R+1; `clear_o` at R+N'+1.
  - Retrigger wins over the cnt==1 expiry in the same cycle.
- GAP occupies cycles C … C+`min_gap_p`−1, where C is the `clear_o` cycle. The earliest accepted trigger is at C+`min_gap_p`.
- Minimum set-to-set spacing is N+`min_gap_p`+1 cycles.
- `hold_cycles_i` = 2^`cnt_width_p`−1 must work with no wrap.

## Structure
- Package `qcl_hold_timer_pkg`: `hold_state_e` {IDLE, HOLD, GAP} and default width constants.
- Optional sub-module `qcl_hold_timer_ctr`: loadable down-counter with `load_i`, `val_i`, `dec_i`, `cnt_o`, `is_one_o`.
- The downstream `set_o`/`clear_o` connect one-to-one to the flop's set/reset inputs.

## Test plan
- **Basic window:** N=4, trigger at cycle 10 → `set_o`@11; `remaining_o` 4,3,2,1 at 11–14; `clear_o`@15; `busy_o` 1 from 11 to 15; IDLE at 16 (`min_gap_p`=1).
- **Retrigger:** N=5 at cycle 0, `retrigger_en_i`=1, trigger with N=3 at cycle 4 → no second `set_o`; `remaining_o`=3 at 5; `clear_o`@8.
- **Retrigger disabled and zero length:** trigger in HOLD with `retrigger_en_i`=0 → `drop_o` next cycle, `clear_o` timing unchanged. Trigger with N=0 in IDLE → `drop_o`, no `set_o`.
- **Abort priority:** N=10, `abort_i` and `trigger_i` both high in cycle 3 → `clear_o`@4, no reload. A trigger during GAP gives `drop_o`, no `set_o`.
- **Gap enforcement:** `min_gap_p`=3, N=2, back-to-back triggers held high → `set_o` every 6 cycles; `drop_o` on every rejected cycle; never `set_o & clear_o`.
- **Reset mid-HOLD:** `reset_i` at remaining=7 → next cycle all outputs 0, IDLE, no `clear_o`. A trigger right after reset is accepted normally.

Source files
------------

// File: rtl/qcl_hold_timer_pkg.sv
// Shared types and default sizing for the hold-time sequencer.
package qcl_hold_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } hold_state_e;

  localparam int unsigned QCL_CNT_WIDTH = 16;
  localparam int unsigned QCL_MIN_GAP   = 1;

endpackage

// File: rtl/qcl_hold_timer_ctr.sv
// Loadable down-counter shared by the HOLD window and the GAP interval.
module qcl_hold_timer_ctr #(
  parameter int unsigned width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] val_i,
  input  logic               dec_i,
  output logic [width_p-1:0] cnt_o,
  output logic               is_one_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i)     cnt_o <= '0;
    else if (load_i) cnt_o <= val_i;
    else if (dec_i)  cnt_o <= cnt_o - 1'b1;
  end

  assign is_one_o = (cnt_o == width_p'(1));

endmodule

// File: rtl/qcl_hold_timer.sv
// Hold-time sequencer: set pulse, clear pulse N cycles later, then a forced idle gap.
module qcl_hold_timer
  import qcl_hold_timer_pkg::*;
#(
  parameter int unsigned cnt_width_p = QCL_CNT_WIDTH,
  parameter int unsigned min_gap_p   = QCL_MIN_GAP
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   trigger_i,
  input  logic [cnt_width_p-1:0] hold_cycles_i,
  input  logic                   retrigger_en_i,
  input  logic                   abort_i,
  output logic                   set_o,
  output logic                   clear_o,
  output logic                   busy_o,
  output logic [cnt_width_p-1:0] remaining_o,
  output logic                   drop_o
);

  if (min_gap_p < 1 || (64'(min_gap_p) >> cnt_width_p) != 64'd0) begin : g_bad_gap
    $error("qcl_hold_timer: min_gap_p must be >= 1 and < 2**cnt_width_p");
  end

  localparam logic [cnt_width_p-1:0] GAP_LOAD = cnt_width_p'(min_gap_p);

  hold_state_e            state_q, state_n;
  logic                   set_n, clr_n, drop_n;
  logic                   ld, dec, is_one;
  logic [cnt_width_p-1:0] ld_val, cnt;
  logic                   n_nz;

  assign n_nz = (hold_cycles_i != '0);

  qcl_hold_timer_ctr #(.width_p(cnt_width_p)) u_ctr (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (ld),
    .val_i    (ld_val),
    .dec_i    (dec),
    .cnt_o    (cnt),
    .is_one_o (is_one)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      set_o   <= 1'b0;
      clear_o <= 1'b0;
      drop_o  <= 1'b0;
    end else begin
      state_q <= state_n;
      set_o   <= set_n;
      clear_o <= clr_n;
      drop_o  <= drop_n;
    end
  end

  always_comb begin
    state_n = state_q;
    set_n   = 1'b0;
    clr_n   = 1'b0;
    drop_n  = 1'b0;
    ld      = 1'b0;
    ld_val  = '0;
    dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger_i) begin
          if (n_nz) begin
            state_n = HOLD;
            ld      = 1'b1;
            ld_val  = hold_cycles_i;
            set_n   = 1'b1;
          end else begin
            drop_n  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (abort_i) begin
          clr_n   = 1'b1;
          state_n = GAP;
          ld      = 1'b1;
          ld_val  = GAP_LOAD;
        end else if (trigger_i && retrigger_en_i && n_nz) begin
          // Reload beats expiry: a retrigger on the last cycle still extends.
          ld      = 1'b1;
          ld_val  = hold_cycles_i;
        end else begin
          drop_n = trigger_i;
          if (is_one) begin
            clr_n   = 1'b1;
            state_n = GAP;
            ld      = 1'b1;
            ld_val  = GAP_LOAD;
          end else begin
            dec = 1'b1;
          end
        end
      end
      GAP: begin
        drop_n = trigger_i;
        if (is_one) begin
          state_n = IDLE;
          ld      = 1'b1;
        end else begin
          dec = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_o      = (state_q != IDLE);
  assign remaining_o = (state_q == HOLD) ? cnt : '0;

  // Downstream flop treats simultaneous set and reset as fatal.
  a_no_set_clr: assert property (@(posedge clk_i) !(set_o && clear_o));

endmodule

// File: tb/tb_qcl_hold_timer.sv
// Randomized + directed check of qcl_hold_timer against a time-stamp based window model.
module tb_qcl_hold_timer;

  logic        clk = 1'b0;
  logic        rst, trig, ren, abort;
  logic [15:0] n;

  logic        set0, clr0, busy0, drop0;
  logic [15:0] rem0;
  logic        set1, clr1, busy1, drop1;
  logic [3:0]  rem1;

  always #5 clk = ~clk;

  qcl_hold_timer #(.cnt_width_p(16), .min_gap_p(1)) dut0 (
    .clk_i(clk), .reset_i(rst), .trigger_i(trig), .hold_cycles_i(n),
    .retrigger_en_i(ren), .abort_i(abort), .set_o(set0), .clear_o(clr0),
    .busy_o(busy0), .remaining_o(rem0), .drop_o(drop0));

  qcl_hold_timer #(.cnt_width_p(4), .min_gap_p(3)) dut1 (
    .clk_i(clk), .reset_i(rst), .trigger_i(trig), .hold_cycles_i(n[3:0]),
    .retrigger_en_i(ren), .abort_i(abort), .set_o(set1), .clear_o(clr1),
    .busy_o(busy1), .remaining_o(rem1), .drop_o(drop1));

  int vectors = 0;
  int fails   = 0;
  int t       = 0;
  bit chk_en  = 1'b0;

  // Model: a window is described by the absolute cycle of its clear pulse and
  // the absolute cycle at which the block is idle again.
  int gap_of[2] = '{1, 3};
  bit in_hold[2];
  int clr_at[2];
  int idle_at[2];
  bit e_set[2], e_clr[2], e_drop[2], e_busy[2];
  int e_rem[2];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc %0d: got %0d want %0d", nm, k, t, act, exp);
    end
  endtask

  task automatic model(input int k);
    int nn;
    bit s, c, d;
    nn = (k == 1) ? int'(n[3:0]) : int'(n);
    s = 0; c = 0; d = 0;
    if (rst) begin
      in_hold[k] = 0;
      idle_at[k] = t + 1;
    end else if (in_hold[k]) begin
      if (abort) begin
        c = 1; in_hold[k] = 0; idle_at[k] = t + 1 + gap_of[k];
      end else if (trig && ren && nn != 0) begin
        clr_at[k] = t + 1 + nn;
      end else begin
        d = trig;
        if (clr_at[k] == t + 1) begin
          c = 1; in_hold[k] = 0; idle_at[k] = t + 1 + gap_of[k];
        end
      end
    end else if (t >= idle_at[k]) begin
      if (trig) begin
        if (nn != 0) begin
          s = 1; in_hold[k] = 1; clr_at[k] = t + 1 + nn;
        end else d = 1;
      end
    end else begin
      d = trig;
    end
    e_set[k]  = s;
    e_clr[k]  = c;
    e_drop[k] = d;
    e_busy[k] = in_hold[k] || (t + 1 < idle_at[k]);
    e_rem[k]  = in_hold[k] ? clr_at[k] - (t + 1) : 0;
  endtask

  task automatic step();
    @(posedge clk);
    model(0);
    model(1);
    t++;
    @(negedge clk);
  endtask

  task automatic cmp_dut(input int k, input logic s, input logic c, input logic d,
                         input logic b, input logic [15:0] r);
    chk("set", k, 32'(s), 32'(e_set[k]));
    chk("clear", k, 32'(c), 32'(e_clr[k]));
    chk("drop", k, 32'(d), 32'(e_drop[k]));
    chk("busy", k, 32'(b), 32'(e_busy[k]));
    chk("remaining", k, 32'(r), 32'(e_rem[k]));
    chk("set_and_clear", k, 32'(s & c), 32'd0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut(0, set0, clr0, drop0, busy0, rem0);
      cmp_dut(1, set1, clr1, drop1, busy1, 16'(rem1));
    end
  end

  task automatic idle(input int cycles);
    trig = 0; abort = 0;
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    int last0, last1;
    rst = 1; trig = 0; ren = 0; abort = 0; n = '0;
    for (int k = 0; k < 2; k++) begin
      in_hold[k] = 0; idle_at[k] = 0; clr_at[k] = 0;
    end
    step(); step();
    chk_en = 1;
    chk("reset_set", 0, 32'(set0), 32'd0);
    chk("reset_busy", 0, 32'(busy0), 32'd0);
    chk("reset_rem", 0, 32'(rem0), 32'd0);
    rst = 0;
    idle(3);

    // Basic window, N=4
    trig = 1; n = 4; step(); trig = 0;
    chk("basic_set", 0, 32'(set0), 32'd1);
    chk("basic_rem4", 0, 32'(rem0), 32'd4);
    step(); chk("basic_rem3", 0, 32'(rem0), 32'd3);
    step(); step(); chk("basic_rem1", 0, 32'(rem0), 32'd1);
    step(); chk("basic_clear", 0, 32'(clr0), 32'd1);
    chk("basic_busy_gap", 0, 32'(busy0), 32'd1);
    step(); chk("basic_idle", 0, 32'(busy0), 32'd0);
    idle(4);

    // Retrigger: N=5 then N=3 four cycles later
    ren = 1; trig = 1; n = 5; step(); trig = 0;
    chk("rt_rem5", 0, 32'(rem0), 32'd5);
    step(); step(); step();
    trig = 1; n = 3; step(); trig = 0;
    chk("rt_no_set", 0, 32'(set0), 32'd0);
    chk("rt_rem3", 0, 32'(rem0), 32'd3);
    step(); step(); step();
    chk("rt_clear", 0, 32'(clr0), 32'd1);
    idle(5);

    // Retrigger disabled and zero length
    ren = 0; trig = 1; n = 4; step();
    step(); trig = 0;
    chk("rd_drop", 0, 32'(drop0), 32'd1);
    chk("rd_rem3", 0, 32'(rem0), 32'd3);
    step(); step(); step();
    chk("rd_clear", 0, 32'(clr0), 32'd1);
    idle(5);
    trig = 1; n = 0; step(); trig = 0;
    chk("zero_drop", 0, 32'(drop0), 32'd1);
    chk("zero_no_set", 0, 32'(set0), 32'd0);
    idle(2);

    // Abort wins over a simultaneous retrigger
    ren = 1; trig = 1; n = 10; step(); trig = 0;
    step(); step();
    abort = 1; trig = 1; step(); abort = 0;
    chk("abort_clear", 0, 32'(clr0), 32'd1);
    chk("abort_rem", 0, 32'(rem0), 32'd0);
    step();
    chk("gap_drop", 0, 32'(drop0), 32'd1);
    chk("gap_no_set", 0, 32'(set0), 32'd0);
    idle(16);

    // Gap enforcement with trigger held high, N=2
    ren = 0; trig = 1; n = 2; last0 = -1; last1 = -1;
    for (int i = 0; i < 26; i++) begin
      step();
      if (set0 === 1'b1) begin
        if (last0 >= 0) chk("spacing", 0, 32'(t - last0), 32'd4);
        last0 = t;
      end
      if (set1 === 1'b1) begin
        if (last1 >= 0) chk("spacing", 1, 32'(t - last1), 32'd6);
        last1 = t;
      end
    end
    idle(8);

    // Reset mid-HOLD, then immediate trigger
    trig = 1; n = 10; step(); trig = 0;
    step(); step(); step();
    chk("pre_reset_rem", 0, 32'(rem0), 32'd7);
    rst = 1; step(); rst = 0;
    chk("rst_clear", 0, 32'(clr0), 32'd0);
    chk("rst_busy", 0, 32'(busy0), 32'd0);
    trig = 1; n = 3; step(); trig = 0;
    chk("post_rst_set", 0, 32'(set0), 32'd1);
    chk("post_rst_rem", 1, 32'(rem1), 32'd3);
    idle(8);

    // Full-scale N on the narrow instance must not wrap
    trig = 1; n = 16'd15; step(); trig = 0;
    chk("max_rem", 1, 32'(rem1), 32'd15);
    for (int i = 0; i < 14; i++) step();
    chk("max_rem1", 1, 32'(rem1), 32'd1);
    step();
    chk("max_clear", 1, 32'(clr1), 32'd1);
    idle(5);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      trig  = ($urandom_range(0, 99) < 30);
      abort = ($urandom_range(0, 99) < 5);
      ren   = $urandom_range(0, 1);
      n     = 16'($urandom_range(0, 20));
      step();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
